led_scan_controller: RTL and testbench

LED_SCAN_CONTROLLER -- requirements
Module: led_scan_controller

---
 rtl/led_scan_controller.sv | 123 ++++++++++++
 tb/tb_led_scan_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_controller.sv
// rtl/led_scan_controller.sv - column-scanning LED driver for a Conway board with one-deep frame buffer
// Blank/show FSM walks the columns; a new frame is staged in pending and swapped in at the frame boundary.
module led_scan_controller #(
  parameter int N     = 5,
  parameter int DWELL = 1000,
  parameter int BLANK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*N-1:0]   cells_in,
  input  logic             cells_valid,
  output logic             cells_ready,
  output logic             ena,
  output logic [$clog2(N):0] x,
  output logic [N*N-1:0]   cells,
  output logic             frame_done
);

  localparam int NN   = N * N;
  localparam int XW   = $clog2(N) + 1;
  localparam int MAXC = (BLANK > DWELL) ? BLANK : DWELL;
  localparam int CW   = $clog2(MAXC + 1);

  if (N < 1 || N > 8 || DWELL < 1 || BLANK < 1) begin : g_bad_params
    $error("led_scan_controller: illegal parameters N=%0d DWELL=%0d BLANK=%0d", N, DWELL, BLANK);
  end

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XW-1:0]   x_q, x_d;
  logic [NN-1:0]   cells_q, cells_d;
  logic [NN-1:0]   pending_q, pending_d;
  logic            pending_full_q, pending_full_d;
  logic            frame_done_q, frame_done_d;
  logic            boundary;
  logic            handshake;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_BLANK;
      cnt_q          <= '0;
      x_q            <= '0;
      cells_q        <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      x_q            <= x_d;
      cells_q        <= cells_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      frame_done_q   <= frame_done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    x_d            = x_q;
    cells_d        = cells_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    boundary       = 1'b0;
    handshake      = cells_valid && !pending_full_q;

    case (state_q)
      S_BLANK: begin
        if (cnt_q == CW'(BLANK - 1)) begin
          state_d = S_SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHOW: begin
        if (cnt_q == CW'(DWELL - 1)) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          // Column advances only on leaving SHOW, so x is frozen while lit.
          if (x_q == XW'(N - 1)) begin
            x_d      = '0;
            boundary = 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_BLANK;
        cnt_d   = '0;
      end
    endcase

    frame_done_d = boundary;

    if (boundary && pending_full_q) begin
      cells_d        = pending_q;
      pending_full_d = 1'b0;
    end

    // A handshake can only occur with pending empty, so it never collides with the swap above.
    if (handshake) begin
      pending_d      = cells_in;
      pending_full_d = 1'b1;
    end
  end

  assign ena         = (state_q == S_SHOW);
  assign x           = x_q;
  assign cells       = cells_q;
  assign cells_ready = !pending_full_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_led_scan_controller.sv
// tb/tb_led_scan_controller.sv - directed self-checking bench for led_scan_controller (N=5, DWELL=4, BLANK=2)
module tb_led_scan_controller;

  logic        clk;
  logic        rst;
  logic [24:0] cells_in;
  logic        cells_valid;
  logic        cells_ready;
  logic        ena;
  logic [2:0]  x;
  logic [24:0] cells;
  logic        frame_done;

  int n_cmp;
  int n_err;
  int cyc;

  led_scan_controller #(.N(5), .DWELL(4), .BLANK(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .cells_in    (cells_in),
    .cells_valid (cells_valid),
    .cells_ready (cells_ready),
    .ena         (ena),
    .x           (x),
    .cells       (cells),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Leaves the bench at cycle 0: the first cycle after rst is released.
  task automatic do_reset();
    rst = 1'b1;
    cells_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cells_valid = 1'b1;
    cells_in = 25'h1FFFFFF;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cells_valid = 1'b0;
    cyc = 0;
    n_cmp++; if (ena !== 1'b0) begin n_err++; $display("FAIL reset_ena got %b want 0", ena); end
    n_cmp++; if (x !== 3'd0) begin n_err++; $display("FAIL reset_x got %0d want 0", x); end
    n_cmp++; if (cells !== 25'h0) begin n_err++; $display("FAIL reset_cells got %h want 0", cells); end
    n_cmp++; if (cells_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", cells_ready); end
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
  endtask

  task automatic test_free_running();
    logic       e_ena;
    logic [2:0] e_x;
    logic       e_fd;
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      e_ena = (c < 30) && ((c % 6) >= 2);
      e_x   = (c < 30) ? 3'(c / 6) : 3'd0;
      e_fd  = (c == 30);
      n_cmp++; if (ena !== e_ena) begin n_err++; $display("FAIL timing_ena c=%0d got %b want %b", c, ena, e_ena); end
      n_cmp++; if (x !== e_x) begin n_err++; $display("FAIL timing_x c=%0d got %0d want %0d", c, x, e_x); end
      n_cmp++; if (frame_done !== e_fd) begin n_err++; $display("FAIL timing_fd c=%0d got %b want %b", c, frame_done, e_fd); end
      if (c < 30) step();
    end
    step();
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL timing_fd_c31 got %b want 0", frame_done); end
  endtask

  task automatic test_single_load();
    do_reset();
    while (cyc < 3) step();
    cells_in = 25'h1FFFFFF;
    cells_valid = 1'b1;
    step();
    cells_valid = 1'b0;
    cells_in = 25'h0;
    while (cyc < 30) begin
      n_cmp++; if (cells_ready !== 1'b0) begin n_err++; $display("FAIL load_ready c=%0d got %b want 0", cyc, cells_ready); end
      n_cmp++; if (cells !== 25'h0) begin n_err++; $display("FAIL load_cells_early c=%0d got %h want 0", cyc, cells); end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (cells !== 25'h1FFFFFF) begin n_err++; $display("FAIL load_cells c=%0d got %h want 1ffffff", cyc, cells); end
      n_cmp++; if (cells_ready !== 1'b1) begin n_err++; $display("FAIL load_ready_after c=%0d got %b want 1", cyc, cells_ready); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [24:0] a;
    logic [24:0] b;
    a = 25'h0A5A5A5;
    b = 25'h1234567;
    do_reset();
    while (cyc < 3) step();
    cells_in = a;
    cells_valid = 1'b1;
    step();
    cells_in = b;
    while (cyc < 30) begin
      n_cmp++; if (cells_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready c=%0d got %b want 0", cyc, cells_ready); end
      n_cmp++; if (cells !== 25'h0) begin n_err++; $display("FAIL bp_cells_early c=%0d got %h want 0", cyc, cells); end
      step();
    end
    n_cmp++; if (cells_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_c30 got %b want 1", cells_ready); end
    while (cyc < 60) begin
      n_cmp++; if (cells !== a) begin n_err++; $display("FAIL bp_cells_a c=%0d got %h want %h", cyc, cells, a); end
      step();
      if (cyc == 31) cells_valid = 1'b0;
      if (cyc > 30 && cyc < 60) begin
        n_cmp++; if (cells_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_full c=%0d got %b want 0", cyc, cells_ready); end
      end
    end
    n_cmp++; if (cells !== b) begin n_err++; $display("FAIL bp_cells_b got %h want %h", cells, b); end
    n_cmp++; if (cells_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_c60 got %b want 1", cells_ready); end
  endtask

  task automatic test_boundary_race();
    logic [24:0] c_val;
    c_val = 25'h0C3C3C3;
    do_reset();
    while (cyc < 29) step();
    cells_in = c_val;
    cells_valid = 1'b1;
    step();
    cells_valid = 1'b0;
    n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL race_fd got %b want 1", frame_done); end
    n_cmp++; if (cells_ready !== 1'b0) begin n_err++; $display("FAIL race_ready got %b want 0", cells_ready); end
    while (cyc < 60) begin
      n_cmp++; if (cells !== 25'h0) begin n_err++; $display("FAIL race_cells_hold c=%0d got %h want 0", cyc, cells); end
      step();
    end
    n_cmp++; if (cells !== c_val) begin n_err++; $display("FAIL race_cells got %h want %h", cells, c_val); end
  endtask

  task automatic test_mid_reset();
    logic       e_ena;
    logic [2:0] e_x;
    do_reset();
    while (cyc < 3) step();
    cells_in = 25'h1111111;
    cells_valid = 1'b1;
    step();
    cells_valid = 1'b0;
    while (cyc < 31) step();
    cells_in = 25'h0222222;
    cells_valid = 1'b1;
    step();
    cells_valid = 1'b0;
    n_cmp++; if (cells_ready !== 1'b0) begin n_err++; $display("FAIL mid_pending_full got %b want 0", cells_ready); end
    while (cyc < 50) step();
    n_cmp++; if (x !== 3'd3) begin n_err++; $display("FAIL mid_pre_x got %0d want 3", x); end
    n_cmp++; if (ena !== 1'b1) begin n_err++; $display("FAIL mid_pre_ena got %b want 1", ena); end
    n_cmp++; if (cells !== 25'h1111111) begin n_err++; $display("FAIL mid_pre_cells got %h want 1111111", cells); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
    n_cmp++; if (x !== 3'd0) begin n_err++; $display("FAIL mid_x got %0d want 0", x); end
    n_cmp++; if (ena !== 1'b0) begin n_err++; $display("FAIL mid_ena got %b want 0", ena); end
    n_cmp++; if (cells !== 25'h0) begin n_err++; $display("FAIL mid_cells got %h want 0", cells); end
    n_cmp++; if (cells_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready got %b want 1", cells_ready); end
    for (int c = 0; c <= 30; c++) begin
      e_ena = (c < 30) && ((c % 6) >= 2);
      e_x   = (c < 30) ? 3'(c / 6) : 3'd0;
      n_cmp++; if (ena !== e_ena) begin n_err++; $display("FAIL mid_timing_ena c=%0d got %b want %b", c, ena, e_ena); end
      n_cmp++; if (x !== e_x) begin n_err++; $display("FAIL mid_timing_x c=%0d got %0d want %0d", c, x, e_x); end
      if (c < 30) step();
    end
    n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL mid_fd got %b want 1", frame_done); end
    n_cmp++; if (cells !== 25'h0) begin n_err++; $display("FAIL mid_cells_discarded got %h want 0", cells); end
  endtask

  task automatic test_x_stability();
    logic [2:0] x_prev;
    do_reset();
    x_prev = 3'd0;
    for (int k = 0; k < 90; k++) begin
      n_cmp++; if (x > 3'd4) begin n_err++; $display("FAIL xstab_range c=%0d got %0d want <=4", cyc, x); end
      if (ena) begin
        n_cmp++; if (x !== x_prev) begin n_err++; $display("FAIL xstab_change c=%0d got %0d want %0d", cyc, x, x_prev); end
      end
      x_prev = x;
      step();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    rst = 1'b1;
    cells_in = 25'h0;
    cells_valid = 1'b0;
    test_reset();
    test_free_running();
    test_single_load();
    test_back_to_back();
    test_boundary_race();
    test_mid_reset();
    test_x_stability();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
